// File: rtl/dac_12bit_model.sv
// Behavioural 12-bit voltage-output DAC: latches a code on en and drives A_out = Vref*code/4096.
// Optional settling delay enabled by defining DAC_SETTLE_EN (SETTLE_CYCLES edges from accept to update).
module dac_12bit_model #(
  parameter real Vref          = 3.3,
  parameter int  NBITS         = 12,
  parameter int  SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] I_data,
  input  logic             en,
  output real              A_out,
  output logic [NBITS-1:0] A_code,
  output logic             busy,
  output logic             done
);

  generate
    if (NBITS != 12 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_param
      $error("dac_12bit_model: NBITS must be 12 and SETTLE_CYCLES must be 1..255");
    end
  endgenerate

  logic [NBITS-1:0] w_data;
  logic [NBITS-1:0] r_code;
  logic             r_done;

  // Unknown input bits read as 0 so the analogue output can never go X or NaN.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NBITS; i++) begin
      w_data[i] = (I_data[i] === 1'b1);
    end
  end

`ifdef DAC_SETTLE_EN
  typedef enum logic {S_IDLE, S_SETTLE} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_count, w_count_nxt;
  logic [NBITS-1:0] r_pending, w_pending_nxt;
  logic [NBITS-1:0] w_code_nxt;
  logic             w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= 8'd0;
      r_pending <= '0;
      r_code    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
      r_code    <= w_code_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // The update edge is the one where the counter steps from 1 to 0; en there is still ignored.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pending_nxt = r_pending;
    w_code_nxt    = r_code;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_pending_nxt = w_data;
          w_count_nxt   = 8'(SETTLE_CYCLES);
          w_state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_count <= 8'd1) begin
          w_code_nxt  = r_pending;
          w_done_nxt  = 1'b1;
          w_count_nxt = 8'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_SETTLE);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= en;
      if (en) begin
        r_code <= w_data;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign A_code = r_code;
  assign done   = r_done;
  // Division by a power of two is exact, so A_out tracks the bit-weighted sum of the code.
  assign A_out  = Vref * real'(r_code) / (2.0 ** NBITS);

endmodule

// File: tb/tb_dac_12bit_model.sv
// Directed self-checking bench for dac_12bit_model; expected volts come from a bit-weighted model.
// Builds against either the default or the DAC_SETTLE_EN variant of the design.
module tb_dac_12bit_model;

  localparam real VREF = 3.3;
`ifdef DAC_SETTLE_EN
  localparam int  LAT      = 5;
  localparam real EXP_BUSY = 1.0;
`else
  localparam int  LAT      = 1;
  localparam real EXP_BUSY = 0.0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] I_data;
  logic        en;
  real         A_out;
  logic [11:0] A_code;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dac_12bit_model #(
    .Vref(VREF),
    .NBITS(12),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .I_data(I_data),
    .en(en),
    .A_out(A_out),
    .A_code(A_code),
    .busy(busy),
    .done(done)
  );

  function automatic real modelVolts(input logic [11:0] code);
    real v;
    v = 0.0;
    for (int i = 0; i < 12; i++) begin
      if (code[i]) v = v + VREF / (2.0 ** (12 - i));
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input real observed, input real expected, input real tol);
    total++;
    if ((observed - expected) > tol || (expected - observed) > tol) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0.9f expected=%0.9f", tag, observed, expected);
    end
  endtask

  // Pulses en for one cycle just after a negedge, then waits (bounded) for done.
  task automatic applyStimulus(input logic [11:0] code, input string tag);
    int lat;
    I_data = code;
    en     = 1'b1;
    @(negedge clk);
    en     = 1'b0;
    I_data = 12'($urandom);
    checkOutput({tag, "_busy"}, real'(busy), EXP_BUSY, 0.0);
    lat = 1;
    while (done !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, real'(lat), real'(LAT), 0.0);
    checkOutput({tag, "_code"}, real'(A_code), real'(code), 0.0);
    @(negedge clk);
    checkOutput({tag, "_donew"}, real'(done), 0.0, 0.0);
  endtask

  logic [11:0] seqCode [4] = '{12'd4000, 12'd500, 12'd4095, 12'd0};
  real         seqVolt [4] = '{3.222656, 0.402832, 3.299194, 0.0};
  int          doneCnt;
  logic [11:0] rc;

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    I_data = 12'd0;
    #2;
    checkOutput("rst_out", A_out, 0.0, 0.0);
    checkOutput("rst_code", real'(A_code), 0.0, 0.0);
    checkOutput("rst_busy", real'(busy), 0.0, 0.0);
    checkOutput("rst_done", real'(done), 0.0, 0.0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    doneCnt = 0;
    repeat (100) begin
      I_data = 12'($urandom);
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("idle_out", A_out, 0.0, 0.0);
    checkOutput("idle_code", real'(A_code), 0.0, 0.0);
    checkOutput("idle_done", real'(doneCnt), 0.0, 0.0);

    applyStimulus(12'd1000, "c1000");
    checkOutput("c1000_v", A_out, 0.805664, 1e-6);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(seqCode[k], "seq");
      checkOutput("seq_v", A_out, seqVolt[k], 1e-6);
      repeat (1000) begin
        I_data = 12'($urandom);
        @(negedge clk);
      end
      checkOutput("seq_hold_v", A_out, seqVolt[k], 1e-6);
      checkOutput("seq_hold_code", real'(A_code), real'(seqCode[k]), 0.0);
    end

`ifdef DAC_SETTLE_EN
    I_data = 12'd1000;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    I_data = 12'd3000;
    en     = 1'b1;
    @(negedge clk);
    en = 1'b0;
    checkOutput("ign_busy", real'(busy), 1.0, 0.0);
    checkOutput("ign_hold_code", real'(A_code), 0.0, 0.0);
    doneCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("ign_done", real'(doneCnt), 1.0, 0.0);
    checkOutput("ign_code", real'(A_code), 1000.0, 0.0);
    checkOutput("ign_v", A_out, 0.805664, 1e-6);
`else
    I_data = 12'd111;
    en     = 1'b1;
    @(negedge clk);
    checkOutput("b2b_code1", real'(A_code), 111.0, 0.0);
    checkOutput("b2b_done1", real'(done), 1.0, 0.0);
    I_data = 12'd2222;
    @(negedge clk);
    en = 1'b0;
    checkOutput("b2b_code2", real'(A_code), 2222.0, 0.0);
    checkOutput("b2b_done2", real'(done), 1.0, 0.0);
    @(negedge clk);
    checkOutput("b2b_done3", real'(done), 0.0, 0.0);
`endif

    for (int n = 0; n < 1000; n++) begin
      rc = 12'($urandom);
      applyStimulus(rc, "rnd");
      checkOutput("rnd_v", A_out, modelVolts(rc), 1e-9);
    end

    applyStimulus(12'd3972, "pre_rst");
    checkOutput("pre_rst_v", A_out, 3.2000976563, 1e-6);
    I_data = 12'd123;
    en     = 1'b1;
`ifdef DAC_SETTLE_EN
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", real'(busy), 1.0, 0.0);
`endif
    checkOutput("rst_pre_hold", A_out, 3.2000976563, 1e-6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out", A_out, 0.0, 0.0);
    checkOutput("arst_code", real'(A_code), 0.0, 0.0);
    checkOutput("arst_busy", real'(busy), 0.0, 0.0);
    checkOutput("arst_done", real'(done), 0.0, 0.0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    doneCnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("post_rst_done", real'(doneCnt), 0.0, 0.0);
    checkOutput("post_rst_code", real'(A_code), 0.0, 0.0);
    checkOutput("post_rst_out", A_out, 0.0, 0.0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dac_12bit_model.md
Name: dac_12bit_model

Overview:
Behavioural 12-bit voltage-output DAC model for simulation of the sine-wave signal chain.
- Samples a 12-bit unsigned code on a start-of-conversion strobe and drives a real-valued analogue output equal to Vref*code/4096.
- Clocked by the system 100 MHz clock from the clock generator; the clock generator is not part of this block.
- Also exposes the latched code and busy/done status so digital logic and benches can track conversions.

Parameters:
- Vref, 3.3 (real), full-scale reference voltage in volts; first positional parameter.
- NBITS, 12, code width; this block supports only 12.
- SETTLE_CYCLES, 4, settling delay in clk cycles; used only when DAC_SETTLE_EN is defined; legal range 1..255.

Ports:
- clk  input  1  system clock, 100 MHz nominal, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- I_data  input  12  unsigned input code; LSB is bit 0.
- en  input  1  start-of-conversion strobe, sampled on the rising edge of clk; typically a 1-cycle pulse.
- A_out  output  real  analogue output voltage in volts (SystemVerilog real port).
- A_code  output  12  code currently driving A_out.
- busy  output  1  high while a conversion is settling.
- done  output  1  1-cycle pulse on the edge where A_out takes a new value.

Behaviour:
- Reset (rst_n low, asynchronous): A_out=0.0, A_code=0, busy=0, done=0, internal counter=0. Outputs hold these values until the first accepted en after rst_n deasserts.
- Transfer function: A_out = Vref * A_code / 4096.0.
  - Computed in real arithmetic with no rounding; A_out is exactly equal to the sum over i of Vref*I_data[i]/2^(12-i).
  - Code 0 gives 0.0 V; code 4095 gives Vref*4095/4096. Full scale Vref is never reached.
- X/Z bits of I_data sampled on an accepted en are converted as 0. The output must never become NaN or X.
- en low: all outputs hold; done=0.
- Default build (no DAC_SETTLE_EN):
  - On a rising edge with en=1, I_data is latched into A_code and A_out updates at that same edge (zero-cycle latency).
  - done=1 for that one cycle.
  - busy is always 0.
  - en held high for consecutive cycles converts every cycle.
- I_data changes while en=0 have no effect on the outputs.
- Reset asserted mid-conversion aborts it: outputs return to their reset values immediately and the pending code is discarded.

Optional Feature:
Macro DAC_SETTLE_EN.
- When defined, an accepted en (edge with en=1 and busy=0):
  - latches I_data into a pending register;
  - sets busy=1 and loads counter=SETTLE_CYCLES.
- While busy, the counter decrements each cycle. At the edge where it reaches 0:
  - A_code<=pending and A_out updates;
  - done=1 for that cycle; busy=0.
- A_out therefore updates exactly SETTLE_CYCLES cycles after the accepted en edge and holds the old value until then.
- en while busy=1 is ignored; no queueing.
- en on the same edge that busy falls is ignored (busy is still 1 at that edge); the next conversion is accepted on the following edge.
- When undefined, behaviour is the default build above and the pending register and counter are not instantiated.

Test Plan:
- Reset, then hold en=0 for 100 cycles with I_data toggling randomly -> A_out=0.0, A_code=0, done never asserts.
- I_data=1000, 1-cycle en pulse -> A_out=0.805664 V (±1e-6), A_code=1000, one done pulse. Default build: update at the en edge. DAC_SETTLE_EN with SETTLE_CYCLES=4: update 4 cycles later, busy high during those 4 cycles.
- Sequence of codes 4000, 500, 4095, 0, each with a 1-cycle en pulse and a 10 us gap -> A_out = 3.222656, 0.402832, 3.299194, 0.000000 V respectively, held constant between pulses.
- 1000 random codes, each with an en pulse -> A_out matches the bench bit-weighted sum Vref*Σ bit_i/2^(12-i) within 1e-9.
- DAC_SETTLE_EN: second en arriving 2 cycles after the first, with a different code -> ignored; A_out reflects only the first code, single done pulse.
- Assert rst_n low with A_out at 3.2 V (and, under DAC_SETTLE_EN, mid-settle) -> A_out=0.0, busy=0, done=0 immediately without waiting for a clock edge; the pending code never appears.
